// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared widths and window-feeder state encoding for the conv path.
// Revision : 1.0
// ============================================================================
package conv_pkg;

  localparam int CONV_DATA_W  = 8;
  localparam int CONV_VEC_LEN = 9;

  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_KLOAD  = 2'd1;
  localparam logic [ST_W-1:0] ST_READY  = 2'd2;
  localparam logic [ST_W-1:0] ST_STREAM = 2'd3;

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Brief    : One-row pixel delay addressed by column; read-before-write.
// Revision : 1.0
// ============================================================================
module line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int DEPTH  = 28,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // Contents are not reset: every entry is rewritten a full row before it is used.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[addr] <= din;
    end
  end

  assign dout = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_feeder
// Brief    : Loads a 3x3 kernel, then streams a raster frame into 3x3 windows.
// Revision : 1.0
// ============================================================================
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  localparam int VEC_LEN = CONV_VEC_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ker_wr,
  input  logic [DATA_W-1:0]         ker_data,
  input  logic                      pix_valid,
  input  logic [DATA_W-1:0]         pix_in,
  output logic                      pix_ready,
  output logic [DATA_W*VEC_LEN-1:0] img_vec,
  output logic [DATA_W*VEC_LEN-1:0] ker_vec,
  output logic                      valid_out,
  output logic                      frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);

  logic [ST_W-1:0]              r_state;
  logic [ST_W-1:0]              w_state_nxt;
  logic [3:0]                   r_ker_cnt;
  logic [DATA_W*VEC_LEN-1:0]    r_ker_vec;
  logic [DATA_W*VEC_LEN-1:0]    r_img_vec;
  logic [DATA_W*VEC_LEN-1:0]    w_win;
  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             r_row;
  logic                         r_valid_out;
  logic                         r_frame_done;
  logic                         w_accept;
  logic                         w_last_pix;
  logic                         w_win_hit;
  logic [DATA_W-1:0]            w_row1_pix;
  logic [DATA_W-1:0]            w_row2_pix;
  logic [2:0][DATA_W-1:0]       w_fresh;
  logic [2:0][1:0][DATA_W-1:0]  r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (ker_wr) w_state_nxt = ST_KLOAD;
      ST_KLOAD:  if (ker_wr && (r_ker_cnt == 4'(VEC_LEN - 1))) w_state_nxt = ST_READY;
      ST_READY: begin
        if (ker_wr) begin
          w_state_nxt = ST_KLOAD;
        end else if (w_accept) begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: if (w_accept && w_last_pix) w_state_nxt = ST_READY;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // A kernel reload requested in READY wins over a pixel offered that cycle.
  always_comb begin
    pix_ready = 1'b0;
    case (r_state)
      ST_READY:  pix_ready = !ker_wr;
      ST_STREAM: pix_ready = 1'b1;
      default:   pix_ready = 1'b0;
    endcase
  end

  assign w_accept   = pix_valid && pix_ready;
  assign w_last_pix = (r_row == c_row_last) && (r_col == c_col_last);
  assign w_win_hit  = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ker_cnt <= '0;
      r_ker_vec <= '0;
    end else if (ker_wr) begin
      if ((r_state == ST_IDLE) || (r_state == ST_READY)) begin
        r_ker_vec[DATA_W-1:0] <= ker_data;
        r_ker_cnt             <= 4'd1;
      end else if (r_state == ST_KLOAD) begin
        for (int i = 0; i < VEC_LEN; i++) begin
          if (r_ker_cnt == 4'(i)) begin
            r_ker_vec[i*DATA_W +: DATA_W] <= ker_data;
          end
        end
        r_ker_cnt <= r_ker_cnt + 4'd1;
      end
    end
  end

  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb_row1 (
    .clk   (clk),
    .wr_en (w_accept),
    .addr  (r_col),
    .din   (pix_in),
    .dout  (w_row1_pix)
  );

  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb_row2 (
    .clk   (clk),
    .wr_en (w_accept),
    .addr  (r_col),
    .din   (w_row1_pix),
    .dout  (w_row2_pix)
  );

  // Column c of rows r-2, r-1, r arriving with the accepted pixel.
  assign w_fresh[0] = w_row2_pix;
  assign w_fresh[1] = w_row1_pix;
  assign w_fresh[2] = pix_in;

  always_comb begin
    w_win = '0;
    for (int ro = 0; ro < 3; ro++) begin
      w_win[(ro*3 + 0)*DATA_W +: DATA_W] = r_hist[ro][0];
      w_win[(ro*3 + 1)*DATA_W +: DATA_W] = r_hist[ro][1];
      w_win[(ro*3 + 2)*DATA_W +: DATA_W] = w_fresh[ro];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_hist       <= '0;
      r_img_vec    <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_win_hit;
      r_frame_done <= w_win_hit && w_last_pix;
      if (w_win_hit) begin
        r_img_vec <= w_win;
      end
      if (w_accept) begin
        for (int ro = 0; ro < 3; ro++) begin
          r_hist[ro][0] <= r_hist[ro][1];
          r_hist[ro][1] <= w_fresh[ro];
        end
        if (r_col == c_col_last) begin
          r_col <= '0;
          r_row <= (r_row == c_row_last) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign img_vec    = r_img_vec;
  assign ker_vec    = r_ker_vec;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_feeder
// Brief    : Randomized bench for conv_window_feeder against a frame-array model.
// Revision : 1.0
// ============================================================================
module tb_conv_window_feeder;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int VL = 9;
  localparam int VW = DW * VL;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          ker_wr;
  logic [DW-1:0] ker_data;
  logic          pix_valid;
  logic [DW-1:0] pix_in;
  logic          pix_ready;
  logic [VW-1:0] img_vec;
  logic [VW-1:0] ker_vec;
  logic          valid_out;
  logic          frame_done;

  always #5 clk = ~clk;

  conv_window_feeder #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ker_wr     (ker_wr),
    .ker_data   (ker_data),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .pix_ready  (pix_ready),
    .img_vec    (img_vec),
    .ker_vec    (ker_vec),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the frame as a 2-D array, the kernel as a lane array.
  logic [DW-1:0] m_img [H][W];
  logic [DW-1:0] m_kv  [VL];
  int            m_idx;
  int            m_kcnt;
  int            m_acc;
  bit            m_loading;
  bit            m_have_ker;
  logic [VW-1:0] m_last_win;

  int            obs_wins;
  int            obs_fd;
  logic [VW-1:0] obs_first;
  logic [VW-1:0] obs_last;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_kv();
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*DW +: DW] = m_kv[i];
    return v;
  endfunction

  function automatic logic [VW-1:0] model_win(input int r, input int c);
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*DW +: DW] = m_img[r - 2 + i/3][c - 2 + i%3];
    return v;
  endfunction

  // Window of a ramp frame whose top-left pixel value is base.
  function automatic logic [VW-1:0] ramp_win(input int base);
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*DW +: DW] = DW'(base + (i/3)*W + (i%3));
    return v;
  endfunction

  function automatic logic [VW-1:0] seq_kv();
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*DW +: DW] = DW'(i + 1);
    return v;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_kcnt = 0; m_loading = 0; m_have_ker = 0;
    m_last_win = '0;
    for (int i = 0; i < VL; i++) m_kv[i] = '0;
  endtask

  // One clock: drive inputs, check pix_ready, clock, update model, check outputs.
  task automatic cycle(input bit pv, input logic [DW-1:0] pd, input bit kw, input logic [DW-1:0] kd);
    bit            exp_rdy, acc, exp_v, exp_fd;
    logic [VW-1:0] exp_win;
    int            r, c;
    pix_valid = pv; pix_in = pd; ker_wr = kw; ker_data = kd;
    #1;
    exp_rdy = m_have_ker && !(kw && m_idx == 0);
    check("pix_ready", VW'(pix_ready), VW'(exp_rdy));
    acc = pv && exp_rdy;
    @(posedge clk);
    exp_v = 0; exp_fd = 0; exp_win = m_last_win;
    if (kw && m_idx == 0) begin
      if (!m_loading) begin
        m_loading = 1; m_have_ker = 0; m_kcnt = 0;
      end
      m_kv[m_kcnt] = kd;
      m_kcnt++;
      if (m_kcnt == VL) begin
        m_loading = 0; m_have_ker = 1;
      end
    end
    if (acc) begin
      r = m_idx / W; c = m_idx % W;
      m_img[r][c] = pd;
      if (r >= 2 && c >= 2) begin
        exp_v = 1; exp_win = model_win(r, c); exp_fd = (m_idx == NPIX - 1);
        m_last_win = exp_win;
      end
      m_idx = (m_idx + 1) % NPIX;
      m_acc++;
    end
    #1;
    check("valid_out", VW'(valid_out), VW'(exp_v));
    check("frame_done", VW'(frame_done), VW'(exp_fd));
    check("img_vec", img_vec, exp_win);
    check("ker_vec", ker_vec, model_kv());
    if (valid_out) begin
      if (obs_wins == 0) obs_first = img_vec;
      obs_last = img_vec;
      obs_wins++;
    end
    if (frame_done) obs_fd++;
  endtask

  task automatic do_reset();
    rst = 1'b1; pix_valid = 1'b0; ker_wr = 1'b0;
    #1;
    model_reset();
    check("rst_pix_ready", VW'(pix_ready), '0);
    check("rst_valid_out", VW'(valid_out), '0);
    check("rst_frame_done", VW'(frame_done), '0);
    check("rst_img_vec", img_vec, '0);
    check("rst_ker_vec", ker_vec, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_kernel(input bit rnd);
    for (int k = 0; k < VL; k++) begin
      cycle(1'b0, '0, 1'b1, rnd ? DW'($urandom) : DW'(k + 1));
    end
  endtask

  // Feed count accepted pixels; kpulse >= 0 fires ker_wr=-1 at that pixel.
  task automatic feed(input int base, input int count, input bit gaps, input bit rnd, input int kpulse);
    int  start, budget, n;
    bit  pulsed, pv, kw;
    start = m_acc; budget = 20 * count; pulsed = 0;
    while ((m_acc - start) < count && budget > 0) begin
      n  = m_acc - start;
      pv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      kw = (kpulse >= 0) && (n == kpulse) && !pulsed;
      if (kw) pulsed = 1;
      cycle(pv, rnd ? DW'($urandom) : DW'(base + n), kw, 8'hFF);
      budget--;
    end
    check("feed_within_budget", VW'(m_acc - start), VW'(count));
  endtask

  task automatic frame(input int base, input bit gaps, input bit rnd, input int kpulse);
    obs_wins = 0; obs_fd = 0; obs_first = '0; obs_last = '0;
    feed(base, NPIX, gaps, rnd, kpulse);
    check("frame_windows", VW'(obs_wins), VW'((W - 2) * (H - 2)));
    check("frame_done_count", VW'(obs_fd), VW'(1));
    if (!rnd) begin
      check("first_window", obs_first, ramp_win(base));
      check("last_window", obs_last, ramp_win(base + 2 * W + 2));
    end
  endtask

  initial begin
    rst = 1'b1; ker_wr = 1'b0; ker_data = '0; pix_valid = 1'b0; pix_in = '0;
    m_acc = 0;
    obs_wins = 0; obs_fd = 0;
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) m_img[r][c] = '0;
    do_reset();

    // No kernel yet: pixels must be refused.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd5, 1'b0, '0);

    load_kernel(1'b0);
    check("ker_vec_seq", ker_vec, seq_kv());

    frame(0, 1'b0, 1'b0, -1);
    frame(0, 1'b1, 1'b0, -1);
    frame(0, 1'b1, 1'b0, 7);
    check("ker_vec_after_pulse", ker_vec, seq_kv());

    // Back-to-back frames, second continuing the ramp at 25.
    frame(0, 1'b0, 1'b0, -1);
    frame(25, 1'b0, 1'b0, -1);

    // Reset part-way through a frame.
    feed(0, 12, 1'b0, 1'b0, -1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd3, 1'b0, '0);
    load_kernel(1'b1);
    frame(0, 1'b0, 1'b0, -1);
    frame(0, 1'b1, 1'b1, -1);

    // Reload a kernel from READY, then a random frame with gaps.
    cycle(1'b0, '0, 1'b0, '0);
    load_kernel(1'b1);
    frame(0, 1'b1, 1'b1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
